// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared definitions for the internal-bus source selector
//
// Purpose: mode constants, select classification type and a one-hot helper
//          shared by bus_select_reg, sel_encode and future priority logic.
// Ports:   none (package).

package cpu_bus_pkg;

   localparam int MODE_STRICT   = 0;
   localparam int MODE_PRIORITY = 1;

   typedef enum logic [1:0] {
      SEL_NONE   = 2'd0,
      SEL_SINGLE = 2'd1,
      SEL_MULTI  = 2'd2
   } sel_class_e;

   // True when at most one bit of v is set. A running "seen" bit avoids a
   // full popcount adder: a second set bit after one was seen marks a dup.
   function automatic logic is_onehot0(input logic [31:0] v);
      logic seen;
      logic dup;
      seen = 1'b0;
      dup  = 1'b0;
      for (int i = 0; i < 32; i++) begin
         dup  = dup | (seen & v[i]);
         seen = seen | v[i];
      end
      return !dup;
   endfunction

endpackage

// File: rtl/sel_encode.sv
// rtl/sel_encode.sv - lowest-set-bit encoder with any/multi flags
//
// Purpose: combinational classification of a select vector.
// Ports:
//   sel    in  N        select vector, bit 0 has highest priority
//   idx    out clog2(N) index of the lowest set bit (0 when none set)
//   any    out 1        at least one bit set
//   multi  out 1        two or more bits set

module sel_encode
   import cpu_bus_pkg::*;
#(
   parameter int N = 10,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  sel,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          multi
);

   // Scan from the top down so the last assignment is the lowest set index.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (sel[i]) begin
            idx = IW'(i);
         end
      end
      any   = |sel;
      multi = ~is_onehot0(32'(sel));
   end

endmodule

// File: rtl/bus_select_reg.sv
// rtl/bus_select_reg.sv - registered internal-bus source selector
//
// Purpose: selects one of NUM_SRC sources onto the internal bus through a
//          one-cycle register stage, with keeper/zero idle behaviour, strict
//          or priority handling of multiple selects, and conflict tracking.
// Ports:
//   clk             in  1               rising-edge clock
//   rst_n           in  1               asynchronous active-low reset
//   data_in         in  NUM_SRC*WIDTH   source i at [i*WIDTH +: WIDTH]
//   select          in  NUM_SRC         bit i selects source i
//   en              in  1               capture enable, 0 = all state holds
//   conflict_clr    in  1               clears sticky flag and counter (when en)
//   bus_out         out WIDTH           registered bus value
//   bus_valid       out 1               bus_out came from a valid selection
//   src_idx         out clog2(NUM_SRC)  index of last valid selection
//   conflict        out 1               multiple selects in captured cycle
//   conflict_sticky out 1               any conflict since last clear
//   conflict_cnt    out CNT_W           saturating conflict cycle count

module bus_select_reg
   import cpu_bus_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 10,
   parameter int MODE    = 0,
   parameter int HOLD    = 1,
   parameter int CNT_W   = 8,
   localparam int IW = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_SRC*WIDTH-1:0] data_in,
   input  logic [NUM_SRC-1:0]       select,
   input  logic                     en,
   input  logic                     conflict_clr,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_valid,
   output logic [IW-1:0]            src_idx,
   output logic                     conflict,
   output logic                     conflict_sticky,
   output logic [CNT_W-1:0]         conflict_cnt
);

   logic [IW-1:0]    low_idx;
   logic             sel_any;
   logic             sel_multi;
   sel_class_e       sel_class;
   logic [WIDTH-1:0] low_data;

   logic [WIDTH-1:0] bus_q,    bus_d;
   logic             valid_q,  valid_d;
   logic [IW-1:0]    idx_q,    idx_d;
   logic             conf_q,   conf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   sel_encode #(
      .N (NUM_SRC)
   ) u_sel_encode (
      .sel   (select),
      .idx   (low_idx),
      .any   (sel_any),
      .multi (sel_multi)
   );

   always_comb begin
      if (!sel_any) begin
         sel_class = SEL_NONE;
      end else if (sel_multi) begin
         sel_class = SEL_MULTI;
      end else begin
         sel_class = SEL_SINGLE;
      end
   end

   // Data mux keyed by the lowest set index; in strict mode the multi case
   // discards this value, so one mux serves both modes.
   always_comb begin
      low_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (low_idx == IW'(i)) begin
            low_data = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      bus_d    = bus_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      conf_d   = conf_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;

      if (en) begin
         conf_d = (sel_class == SEL_MULTI);

         case (sel_class)
            SEL_SINGLE: begin
               bus_d   = low_data;
               valid_d = 1'b1;
               idx_d   = low_idx;
            end
            SEL_MULTI: begin
               if (MODE == MODE_PRIORITY) begin
                  bus_d   = low_data;
                  valid_d = 1'b1;
                  idx_d   = low_idx;
               end else begin
                  bus_d   = '0;
                  valid_d = 1'b0;
               end
            end
            default: begin
               valid_d = 1'b0;
               if (HOLD == 0) begin
                  bus_d = '0;
               end
            end
         endcase

         // Clear dominates a simultaneous conflict for the count and flag;
         // the conflict pulse above is unaffected.
         if (conflict_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
         end else if (conf_d) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_q    <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         conf_q   <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         bus_q    <= bus_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         conf_q   <= conf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus_out         = bus_q;
   assign bus_valid       = valid_q;
   assign src_idx         = idx_q;
   assign conflict        = conf_q;
   assign conflict_sticky = sticky_q;
   assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_select_reg.sv
// tb/tb_bus_select_reg.sv - self-checking bench for bus_select_reg

module tb_bus_select_reg;

   localparam int NI = 4;
   // Instance 0: strict/keeper, 1: strict/zero-idle, 2: priority, 3: 2-bit counter
   localparam int P_MODE [NI] = '{0, 0, 1, 0};
   localparam int P_HOLD [NI] = '{1, 0, 1, 1};
   localparam int P_CNT  [NI] = '{8, 8, 8, 2};

   logic        clk;
   logic        rst_n;
   logic [79:0] data_in;
   logic [9:0]  select;
   logic        en;
   logic        conflict_clr;

   logic [NI-1:0][7:0] bus_all;
   logic [NI-1:0]      valid_all;
   logic [NI-1:0][3:0] idx_all;
   logic [NI-1:0]      conf_all;
   logic [NI-1:0]      sticky_all;
   logic [NI-1:0][7:0] cnt_all;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [P_CNT[g]-1:0] cnt_w;
      bus_select_reg #(
         .WIDTH   (8),
         .NUM_SRC (10),
         .MODE    (P_MODE[g]),
         .HOLD    (P_HOLD[g]),
         .CNT_W   (P_CNT[g])
      ) dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .data_in         (data_in),
         .select          (select),
         .en              (en),
         .conflict_clr    (conflict_clr),
         .bus_out         (bus_all[g]),
         .bus_valid       (valid_all[g]),
         .src_idx         (idx_all[g]),
         .conflict        (conf_all[g]),
         .conflict_sticky (sticky_all[g]),
         .conflict_cnt    (cnt_w)
      );
      assign cnt_all[g] = 8'(cnt_w);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] bus;
      logic       valid;
      logic [3:0] idx;
      logic       conf;
      logic       sticky;
      int         cnt;
   } mstate_t;

   mstate_t m [NI];

   typedef struct {
      logic [9:0]  sel;
      logic [79:0] data;
      logic        en;
      logic        clr;
      logic [7:0]  e_bus;
      logic        e_valid;
      logic [3:0]  e_idx;
      logic        e_conf;
      logic        e_sticky;
      logic [7:0]  e_cnt;
   } vec_t;

   // Reference: classify by popcount, pick the lowest set index by search.
   function automatic mstate_t model_next(mstate_t s, int mode, int hold, int cw,
                                          logic [79:0] d, logic [9:0] sel,
                                          logic e, logic clr);
      mstate_t n;
      int ones;
      int low;
      n = s;
      if (!e) return s;
      ones = $countones(sel);
      low = 0;
      for (int i = 9; i >= 0; i--) if (sel[i]) low = i;
      n.conf = (ones > 1);
      if (ones == 0) begin
         n.valid = 1'b0;
         if (hold == 0) n.bus = 8'h00;
      end else if (ones == 1 || mode == 1) begin
         n.valid = 1'b1;
         n.idx   = low[3:0];
         n.bus   = d[low*8 +: 8];
      end else begin
         n.valid = 1'b0;
         n.bus   = 8'h00;
      end
      if (clr) begin
         n.cnt    = 0;
         n.sticky = 1'b0;
      end else if (n.conf) begin
         n.sticky = 1'b1;
         if (s.cnt < (1 << cw) - 1) n.cnt = s.cnt + 1;
      end
      return n;
   endfunction

   function automatic logic [79:0] put(logic [79:0] b, int i, logic [7:0] v);
      b[i*8 +: 8] = v;
      return b;
   endfunction

   function automatic vec_t mkv(logic [9:0] sel, logic [79:0] d, logic e, logic c,
                                logic [7:0] bus, logic v, logic [3:0] idx,
                                logic cf, logic st, logic [7:0] cnt);
      vec_t r;
      r.sel = sel; r.data = d; r.en = e; r.clr = c;
      r.e_bus = bus; r.e_valid = v; r.e_idx = idx;
      r.e_conf = cf; r.e_sticky = st; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d actual=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m[i].bus = 8'h00; m[i].valid = 1'b0; m[i].idx = 4'd0;
         m[i].conf = 1'b0; m[i].sticky = 1'b0; m[i].cnt = 0;
      end
   endtask

   task automatic compare_model(string tag);
      for (int i = 0; i < NI; i++) begin
         check({tag, "_bus"},    i, 32'(bus_all[i]),    32'(m[i].bus));
         check({tag, "_valid"},  i, 32'(valid_all[i]),  32'(m[i].valid));
         check({tag, "_idx"},    i, 32'(idx_all[i]),    32'(m[i].idx));
         check({tag, "_conf"},   i, 32'(conf_all[i]),   32'(m[i].conf));
         check({tag, "_sticky"}, i, 32'(sticky_all[i]), 32'(m[i].sticky));
         check({tag, "_cnt"},    i, 32'(cnt_all[i]),    32'(m[i].cnt));
      end
   endtask

   task automatic check_all_zero(string tag);
      for (int i = 0; i < NI; i++) begin
         check({tag, "_bus"},    i, 32'(bus_all[i]),    32'd0);
         check({tag, "_valid"},  i, 32'(valid_all[i]),  32'd0);
         check({tag, "_idx"},    i, 32'(idx_all[i]),    32'd0);
         check({tag, "_conf"},   i, 32'(conf_all[i]),   32'd0);
         check({tag, "_sticky"}, i, 32'(sticky_all[i]), 32'd0);
         check({tag, "_cnt"},    i, 32'(cnt_all[i]),    32'd0);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge,
   // then compare 1 time unit later.
   task automatic step(string tag);
      @(posedge clk);
      for (int i = 0; i < NI; i++)
         m[i] = model_next(m[i], P_MODE[i], P_HOLD[i], P_CNT[i],
                           data_in, select, en, conflict_clr);
      #1;
      compare_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   vec_t tbl [12];
   logic [79:0] bg;

   initial begin
      bg = 80'h0123_4567_89AB_CDEF_1357;
      rst_n = 1'b1;
      data_in = '0;
      select = '0;
      en = 1'b0;
      conflict_clr = 1'b0;
      model_reset();

      tbl[0]  = mkv(10'b0000001000, put(bg, 3, 8'hA5), 1, 0, 8'hA5, 1, 4'd3, 0, 0, 8'd0);
      tbl[1]  = mkv(10'b0000000000, bg,                1, 0, 8'hA5, 0, 4'd3, 0, 0, 8'd0);
      tbl[2]  = mkv(10'b0000000000, bg,                1, 0, 8'hA5, 0, 4'd3, 0, 0, 8'd0);
      tbl[3]  = mkv(10'b0000000000, bg,                1, 0, 8'hA5, 0, 4'd3, 0, 0, 8'd0);
      tbl[4]  = mkv(10'b0000100100, put(put(bg, 2, 8'h11), 5, 8'h22), 1, 0, 8'h00, 0, 4'd3, 1, 1, 8'd1);
      tbl[5]  = mkv(10'b0000100000, put(bg, 5, 8'h22), 1, 0, 8'h22, 1, 4'd5, 0, 1, 8'd1);
      tbl[6]  = mkv(10'b0000000010, put(bg, 1, 8'h77), 0, 0, 8'h22, 1, 4'd5, 0, 1, 8'd1);
      tbl[7]  = mkv(10'b1000000001, bg,                1, 0, 8'h00, 0, 4'd5, 1, 1, 8'd2);
      tbl[8]  = mkv(10'b1000000001, bg,                0, 1, 8'h00, 0, 4'd5, 1, 1, 8'd2);
      tbl[9]  = mkv(10'b0000000000, bg,                1, 1, 8'h00, 0, 4'd5, 0, 0, 8'd0);
      tbl[10] = mkv(10'b1000000000, put(bg, 9, 8'h3C), 1, 0, 8'h3C, 1, 4'd9, 0, 0, 8'd0);
      tbl[11] = mkv(10'b0000000001, put(bg, 0, 8'hC3), 1, 0, 8'hC3, 1, 4'd0, 0, 0, 8'd0);

      // Reset state
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_async");
      @(posedge clk); #1;
      check_all_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven sequence (expected values are for instance 0)
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         select = tbl[k].sel; data_in = tbl[k].data;
         en = tbl[k].en; conflict_clr = tbl[k].clr;
         step("tbl");
         check("tbl_bus",    0, 32'(bus_all[0]),    32'(tbl[k].e_bus));
         check("tbl_valid",  0, 32'(valid_all[0]),  32'(tbl[k].e_valid));
         check("tbl_idx",    0, 32'(idx_all[0]),    32'(tbl[k].e_idx));
         check("tbl_conf",   0, 32'(conf_all[0]),   32'(tbl[k].e_conf));
         check("tbl_sticky", 0, 32'(sticky_all[0]), 32'(tbl[k].e_sticky));
         check("tbl_cnt",    0, 32'(cnt_all[0]),    32'(tbl[k].e_cnt));
         if (k >= 1 && k <= 3) check("zero_idle_bus", 1, 32'(bus_all[1]), 32'h00);
         if (k == 4) begin
            check("prio_bus",   2, 32'(bus_all[2]),   32'h11);
            check("prio_idx",   2, 32'(idx_all[2]),   32'd2);
            check("prio_valid", 2, 32'(valid_all[2]), 32'd1);
            check("prio_conf",  2, 32'(conf_all[2]),  32'd1);
         end
      end

      // Saturation on the 2-bit counter, then clear together with a conflict
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         select = 10'b0000100100; data_in = bg; en = 1'b1; conflict_clr = 1'b0;
         step("sat");
         check("sat_cnt", 3, 32'(cnt_all[3]), (k < 3) ? 32'(k) : 32'd3);
      end
      @(negedge clk);
      conflict_clr = 1'b1;
      step("clr");
      check("clr_cnt",    3, 32'(cnt_all[3]),    32'd0);
      check("clr_sticky", 3, 32'(sticky_all[3]), 32'd0);
      check("clr_conf",   3, 32'(conf_all[3]),   32'd1);
      @(negedge clk);
      conflict_clr = 1'b0;

      // Asynchronous reset between edges, then first enabled edge
      select = 10'b0000001000; data_in = put(bg, 3, 8'hA5);
      step("pre_rst");
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst");
      check("post_rst_bus", 0, 32'(bus_all[0]), 32'hA5);
      check("post_rst_idx", 0, 32'(idx_all[0]), 32'd3);

      // Randomized stimulus against the reference model
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0: select = '0;
            1: select = 10'(1 << $urandom_range(0, 9));
            2: select = 10'($urandom);
            default: select = 10'((1 << $urandom_range(0, 9)) | (1 << $urandom_range(0, 9)));
         endcase
         data_in = {16'($urandom), $urandom, $urandom};
         en = ($urandom_range(0, 9) != 0);
         conflict_clr = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_select_reg.md
Name: bus_select_reg

Overview:
- Parametrised, registered successor to the internal-bus source multiplexer.
- Selects one of NUM_SRC data sources onto the CPU internal bus using per-source select lines.
- Adds a registered output with a hold/keeper option, a priority mode, a stall enable, and multi-select conflict detection with a sticky flag and saturating counter.
- Sits between the register file/ALU/IO sources and the internal data bus consumers.

Parameters:
- WIDTH, 8, bit width of each data source and of the bus.
- NUM_SRC, 10, number of sources; legal range 2..32.
- MODE, 0, 0 = strict one-hot (an invalid select pattern drives zero), 1 = priority (the lowest set index wins).
- HOLD, 1, 1 = bus keeper (the bus holds its last value when no select is set), 0 = the bus drives zero when idle.
- CNT_W, 8, width of the conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- select  in  NUM_SRC  select lines; bit i selects source i.
- en  in  1  capture enable; 0 = stall, and all state holds.
- conflict_clr  in  1  synchronous clear of conflict_sticky and conflict_cnt.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  registered; 1 when bus_out came from a valid selection in the captured cycle.
- src_idx  out  $clog2(NUM_SRC)  registered index of the selected source; holds when no valid selection.
- conflict  out  1  registered one-cycle pulse; more than one select bit was set in the captured cycle.
- conflict_sticky  out  1  set by any conflict; cleared only by reset or conflict_clr.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0.
- Latency: one cycle. Inputs sampled at edge k appear on the outputs after edge k.
- en=0: every register holds, including the conflict counter and the sticky flag. conflict and bus_valid also hold.
- Select classification, combinational each cycle:
  - none = no bits set.
  - single = exactly one bit set.
  - multi = two or more bits set.
- Strict mode (MODE=0):
  - single: bus_out <= selected source; bus_valid=1; src_idx=index.
  - multi: bus_out <= 0; bus_valid=0; src_idx holds; conflict=1.
- Priority mode (MODE=1):
  - single or multi: the lowest set index wins; bus_valid=1; src_idx=that index.
  - multi still raises conflict=1.
- none, either mode: bus_valid=0; src_idx holds; conflict=0.
  - HOLD=1: bus_out holds its previous value.
  - HOLD=0: bus_out <= 0.
- conflict_cnt: increments by 1 on each enabled conflict cycle and saturates at 2^CNT_W-1, with no wrap.
- conflict_sticky: set on any enabled conflict cycle.
- conflict_clr=1 with en=1:
  - conflict_cnt <= 0 and conflict_sticky <= 0.
  - If a conflict occurs in the same cycle, the clear wins for the count and the flag, but the conflict pulse still asserts.
- conflict_clr with en=0: ignored.
- Reset mid-operation returns the block to the reset state immediately. The first post-reset enabled edge behaves normally.
- Indices are zero-based. select bit 0 corresponds to data_in[WIDTH-1:0].

Decomposition:
- Shared package cpu_bus_pkg:
  - MODE_STRICT=0, MODE_PRIORITY=1.
  - Function for a one-hot check (popcount ≤ 1).
- One sub-module, sel_encode: combinational, NUM_SRC → lowest set index, an any flag, and a multi flag. Reused by future interrupt-priority logic.
- The top level holds the data mux, the output registers, and the conflict counter.

Test Plan:
- Reset and capture, WIDTH=8, NUM_SRC=10, MODE=0, HOLD=1:
  - During reset all outputs are 0.
  - Release, then data_in[3]=8'hA5 with select=10'b0000001000 and en=1.
  - Next cycle: bus_out=8'hA5, bus_valid=1, src_idx=3, conflict=0.
- Keeper vs zero:
  - After the capture above, select=0 for 3 cycles.
  - HOLD=1: bus_out stays 8'hA5 with bus_valid=0.
  - HOLD=0 build: bus_out=8'h00.
- Strict conflict:
  - select=10'b0000100100 with data_in[2]=8'h11 and data_in[5]=8'h22.
  - Expect bus_out=8'h00, bus_valid=0, conflict pulse=1, conflict_sticky=1, conflict_cnt=1, src_idx unchanged.
- Priority conflict, MODE=1, same stimulus as the strict case:
  - bus_out=8'h11, src_idx=2, bus_valid=1, conflict=1.
- Saturation and clear, CNT_W=2:
  - 5 consecutive conflict cycles give conflict_cnt=3, with no wrap.
  - conflict_clr=1 together with a conflict: conflict_cnt=0, sticky=0, conflict pulse=1.
- Stall and async reset:
  - en=0 while select and data change: all outputs unchanged.
  - Assert rst_n low between clock edges: outputs go to 0 before the next edge.
